fsm_ab_driver: RTL and testbench

Initiator for the two-input a/b control FSM. It accepts high-level commands over a ready/start handshake and drives the registered a/b stimulus needed to steer the target FSM. It keeps a shadow model of the target and checks the target's y0 (Mealy) and y1 (Moore) outputs every cycle. It sits beside the target on the same clk/reset, and serves as a prototyping exerciser and self-checking traffic source.

---
 rtl/fsm_ab_driver.sv | 186 ++++++++++++++++++
 tb/tb_fsm_ab_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_ab_driver.sv
`default_nettype none
// ============================================================================
// Module   : fsm_ab_driver
// Purpose  : Command-driven a/b stimulus initiator with a shadow checker for
//            the two-input a/b control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_ab_driver #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [1:0]        i_cmd,
  input  logic [HOLD_W-1:0] i_len,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_a,
  output logic              o_b,
  input  logic              i_y0,
  input  logic              i_y1,
  output logic [1:0]        o_state_exp,
  input  logic              i_clr_err,
  output logic              o_err,
  output logic [7:0]        o_err_cnt
);

  localparam logic [1:0] c_S0 = 2'b00;
  localparam logic [1:0] c_S1 = 2'b01;
  localparam logic [1:0] c_S2 = 2'b10;

  localparam logic [1:0] c_CMD_HOLD  = 2'd0;
  localparam logic [1:0] c_CMD_GOTO  = 2'd1;
  localparam logic [1:0] c_CMD_PULSE = 2'd2;

  localparam logic [HOLD_W-1:0] c_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOME = 3'd1,
    ST_ACT  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [1:0]        r_cmd;
  logic [HOLD_W-1:0] r_len;
  logic [HOLD_W-1:0] r_cnt;
  logic              r_homed;
  logic              r_a;
  logic              r_b;
  logic              r_ready;
  logic              r_done;
  logic [1:0]        r_shadow;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  logic [1:0]        w_shadow_nxt;
  logic              w_y0_exp;
  logic              w_y1_exp;
  logic              w_mismatch;

  always_comb begin
    w_shadow_nxt = c_S0;
    case (r_shadow)
      c_S0:    w_shadow_nxt = r_a ? (r_b ? c_S2 : c_S1) : c_S0;
      c_S1:    w_shadow_nxt = r_a ? c_S0 : c_S1;
      default: w_shadow_nxt = c_S0;
    endcase
  end

  assign w_y1_exp   = (r_shadow != c_S2);
  assign w_y0_exp   = (r_shadow == c_S0) & r_a & r_b;
  assign w_mismatch = (i_y0 != w_y0_exp) | (i_y1 != w_y1_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow  <= c_S0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (i_clr_err) begin
        r_err     <= 1'b0;
        r_err_cnt <= 8'd0;
      end else if (w_mismatch) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  // a/b default to 0 every edge; each state only raises what it drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cmd   <= 2'd0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_homed <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_a    <= 1'b0;
      r_b    <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
          if (i_start) begin
            r_cmd   <= i_cmd;
            r_len   <= i_len;
            r_homed <= 1'b0;
            r_ready <= 1'b0;
            r_state <= ST_HOME;
          end
        end
        ST_HOME: begin
          if (!r_homed && (r_shadow == c_S1)) begin
            r_a     <= 1'b1;
            r_homed <= 1'b1;
          end else if (!r_homed && (r_shadow == c_S2)) begin
            r_homed <= 1'b1;
          end else begin
            case (r_cmd)
              c_CMD_GOTO: begin
                r_a     <= 1'b1;
                r_cnt   <= '0;
                r_state <= ST_ACT;
              end
              c_CMD_PULSE: begin
                r_a     <= 1'b1;
                r_b     <= 1'b1;
                r_cnt   <= c_ONE;
                r_state <= ST_ACT;
              end
              c_CMD_HOLD: begin
                if (r_len == '0) begin
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= ST_DONE;
                end else begin
                  r_cnt   <= r_len - c_ONE;
                  r_state <= ST_HOLD;
                end
              end
              default: begin
                r_done  <= 1'b1;
                r_ready <= 1'b1;
                r_state <= ST_DONE;
              end
            endcase
          end
        end
        ST_ACT, ST_HOLD: begin
          // Trailing ACT step (PULSE_S2 cycle 2) and hold cycles both drive a=b=0.
          if (r_cnt == '0) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - c_ONE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_done      = r_done;
  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_state_exp = r_shadow;
  assign o_err       = r_err;
  assign o_err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fsm_ab_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_ab_driver
// Purpose  : Self-checking bench for fsm_ab_driver with a behavioural target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_ab_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] len = 8'd0;
  logic       ready, done, a, b, y0, y1, err, clr_err;
  logic [1:0] state_exp;
  logic [7:0] err_cnt;

  logic [1:0] t_state;
  logic       f_y1_low = 1'b0;
  logic       f_y0_high = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic a;
    logic b;
    logic done;
    logic ready;
  } exp_t;

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  len;
    int          n;
    logic [15:0] ab;
    logic [1:0]  fin;
    bit          poke;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  fsm_ab_driver #(.HOLD_W(8)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_cmd(cmd), .i_len(len),
    .o_ready(ready), .o_done(done), .o_a(a), .o_b(b),
    .i_y0(y0), .i_y1(y1), .o_state_exp(state_exp),
    .i_clr_err(clr_err), .o_err(err), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural target FSM with fault-injection overrides.
  always @(posedge clk or posedge reset) begin
    if (reset) t_state <= 2'd0;
    else begin
      case (t_state)
        2'd0:    t_state <= a ? (b ? 2'd2 : 2'd1) : 2'd0;
        2'd1:    t_state <= a ? 2'd0 : 2'd1;
        default: t_state <= 2'd0;
      endcase
    end
  end
  assign y1 = (t_state != 2'd2) & ~f_y1_low;
  assign y0 = ((t_state == 2'd0) & a & b) | f_y0_high;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_a", {31'd0, a}, {31'd0, e.a});
      chk("sb_b", {31'd0, b}, {31'd0, e.b});
      chk("sb_done", {31'd0, done}, {31'd0, e.done});
      chk("sb_ready", {31'd0, ready}, {31'd0, e.ready});
      chk("sb_state_exp", {30'd0, state_exp}, {30'd0, t_state});
      if (e.a && e.b) chk("sb_y0_pulse", {31'd0, y0}, 32'd1);
    end
  end

  task automatic run_cmd(input vec_t v);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!ready && t < 50) begin @(negedge clk); t++; end
    if (!ready) chk("wait_ready", {31'd0, ready}, 32'd1);
    e = '{a: 1'b0, b: 1'b0, done: 1'b0, ready: 1'b0};
    sb_q.push_back(e);
    for (int i = 0; i < v.n; i++) begin
      e = '{a: v.ab[2*i+1], b: v.ab[2*i], done: 1'b0, ready: 1'b0};
      sb_q.push_back(e);
    end
    e = '{a: 1'b0, b: 1'b0, done: 1'b1, ready: 1'b1};
    sb_q.push_back(e);
    start = 1'b1; cmd = v.cmd; len = v.len;
    @(negedge clk);
    start = 1'b0; cmd = ~v.cmd; len = v.len + 8'd3;
    if (v.poke) begin
      @(negedge clk); @(negedge clk);
      start = 1'b1; cmd = 2'd1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (sb_q.size() > 0 && t < 50) begin @(negedge clk); t++; end
    if (sb_q.size() > 0) begin
      chk("sb_drain", sb_q.size(), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
    chk("post_ready", {31'd0, ready}, 32'd1);
    chk("post_done", {31'd0, done}, 32'd0);
    chk("post_state_exp", {30'd0, state_exp}, {30'd0, v.fin});
    chk("post_err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    int seen;
    clr_err = 1'b0;
    //              cmd   len   n  ab(pair i = {a,b})  fin    poke
    vecs[0] = '{2'd1, 8'd0, 1, 16'h0002, 2'b01, 1'b0}; // GOTO_S1 from S0
    vecs[1] = '{2'd3, 8'd0, 1, 16'h0002, 2'b00, 1'b0}; // HOME from S1
    vecs[2] = '{2'd2, 8'd0, 2, 16'h0003, 2'b00, 1'b0}; // PULSE_S2 from S0
    vecs[3] = '{2'd1, 8'd0, 1, 16'h0002, 2'b01, 1'b0}; // GOTO_S1
    vecs[4] = '{2'd0, 8'd5, 6, 16'h0002, 2'b00, 1'b1}; // HOLD 5 from S1, poked
    vecs[5] = '{2'd0, 8'd0, 0, 16'h0000, 2'b00, 1'b0}; // HOLD 0
    vecs[6] = '{2'd3, 8'd0, 0, 16'h0000, 2'b00, 1'b0}; // HOME from S0
    vecs[7] = '{2'd1, 8'd0, 1, 16'h0002, 2'b01, 1'b0}; // GOTO_S1
    vecs[8] = '{2'd2, 8'd0, 3, 16'h000E, 2'b00, 1'b0}; // PULSE_S2 from S1
    vecs[9] = '{2'd0, 8'd2, 2, 16'h0000, 2'b00, 1'b0}; // HOLD 2 from S0

    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_a", {31'd0, a}, 32'd0);
    chk("rst_b", {31'd0, b}, 32'd0);
    chk("rst_state_exp", {30'd0, state_exp}, 32'd0);
    chk("rst_y1", {31'd0, y1}, 32'd1);
    chk("rst_y0", {31'd0, y0}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

    // y1 forced low for three cycles while the target sits in S0.
    @(negedge clk); f_y1_low = 1'b1;
    repeat (3) @(negedge clk);
    f_y1_low = 1'b0;
    chk("fault_err", {31'd0, err}, 32'd1);
    chk("fault_err_cnt", {24'd0, err_cnt}, 32'd3);
    f_y1_low = 1'b1; clr_err = 1'b1;
    @(negedge clk);
    f_y1_low = 1'b0; clr_err = 1'b0;
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Both outputs wrong in the same cycle count once.
    f_y1_low = 1'b1; f_y0_high = 1'b1;
    repeat (2) @(negedge clk);
    f_y1_low = 1'b0; f_y0_high = 1'b0;
    chk("dual_err_cnt", {24'd0, err_cnt}, 32'd2);

    f_y1_low = 1'b1;
    repeat (260) @(negedge clk);
    f_y1_low = 1'b0;
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("sat_clr_cnt", {24'd0, err_cnt}, 32'd0);

    // Reset during PULSE_S2 cycle 1 abandons the command.
    start = 1'b1; cmd = 2'd2;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("pulse_c1_a", {31'd0, a}, 32'd1);
    chk("pulse_c1_b", {31'd0, b}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_a", {31'd0, a}, 32'd0);
    chk("midrst_b", {31'd0, b}, 32'd0);
    chk("midrst_state_exp", {30'd0, state_exp}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 32'd0);
    run_cmd(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
